// File: rtl/inverter_vector_checker.sv
// Stimulus/response checker for the 9-bit inverter datapath.
// Define INV_CHECK_LFSR_EN to step vectors with a Galois LFSR instead of +1.
module inverter_vector_checker #(
  parameter int WIDTH       = 9,
  parameter int NUM_VECTORS = 16,
  parameter int SETTLE      = 2,
  parameter int ERR_W       = 8,
  parameter int IDX_W       = 8
`ifdef INV_CHECK_LFSR_EN
  ,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 9'h110
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] stim_out,
  input  logic [WIDTH-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [SW-1:0]    settle_cnt;
  logic             captured;

  logic [WIDTH-1:0] stim_nxt;
  logic [WIDTH-1:0] seed_eff;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;

`ifdef INV_CHECK_LFSR_EN
  // An all-zero state would lock the LFSR, so a zero seed starts at 1.
  assign stim_nxt = (stim_out >> 1) ^
                    (stim_out[0] ? LFSR_TAPS : '0);
  assign seed_eff = (seed == '0) ? WIDTH'(1) : seed;
`else
  assign stim_nxt = stim_out + WIDTH'(1);
  assign seed_eff = seed;
`endif

  // resp_in is compared raw; SETTLE covers the inverter's delay.
  assign mismatch = (resp_in != ~stim_out);
  assign err_nxt  = (mismatch && err_count != ERR_MAX)
                  ? err_count + ERR_W'(1)
                  : err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      settle_cnt     <= '0;
      captured       <= 1'b0;
      stim_out       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            stim_out       <= seed_eff;
            idx            <= '0;
            settle_cnt     <= SETTLE_INIT;
            err_count      <= '0;
            pass           <= 1'b0;
            captured       <= 1'b0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            busy           <= 1'b1;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
          end else begin
            err_count <= err_nxt;
            if (mismatch && !captured) begin
              first_err_idx  <= idx;
              first_err_data <= resp_in;
              captured       <= 1'b1;
            end
            // Result is latched with the final sample so it is
            // already valid while done is high.
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
              state <= S_DONE;
            end else begin
              stim_out   <= stim_nxt;
              idx        <= idx + IDX_W'(1);
              settle_cnt <= SETTLE_INIT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inverter_vector_checker.sv
// Directed bench for inverter_vector_checker.
// Four instances cover default, wrap, saturation and short runs.
module tb_inverter_vector_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start [4];
  logic [8:0] seed  [4];
  logic [8:0] stim  [4];
  logic [8:0] resp  [4];
  logic       busy  [4];
  logic       done  [4];
  logic       pass  [4];
  logic [7:0] err   [4];
  logic [7:0] fidx  [4];
  logic [8:0] fdat  [4];
  logic [2:0] err_c;
  logic [8:0] fmask = 9'h1FF;

  assign resp[0] = ~stim[0] & fmask;
  assign resp[1] = ~stim[1];
  assign resp[2] = 9'h000;
  assign resp[3] = ~stim[3];
  assign err[2]  = {5'd0, err_c};

  inverter_vector_checker u_a (
    .clk(clk), .reset(reset), .start(start[0]), .seed(seed[0]),
    .stim_out(stim[0]), .resp_in(resp[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .err_count(err[0]),
    .first_err_idx(fidx[0]), .first_err_data(fdat[0])
  );

  inverter_vector_checker #(.NUM_VECTORS(8)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .seed(seed[1]),
    .stim_out(stim[1]), .resp_in(resp[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .err_count(err[1]),
    .first_err_idx(fidx[1]), .first_err_data(fdat[1])
  );

  inverter_vector_checker #(.ERR_W(3)) u_c (
    .clk(clk), .reset(reset), .start(start[2]), .seed(seed[2]),
    .stim_out(stim[2]), .resp_in(resp[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .err_count(err_c),
    .first_err_idx(fidx[2]), .first_err_data(fdat[2])
  );

  inverter_vector_checker #(.NUM_VECTORS(3)) u_d (
    .clk(clk), .reset(reset), .start(start[3]), .seed(seed[3]),
    .stim_out(stim[3]), .resp_in(resp[3]), .busy(busy[3]),
    .done(done[3]), .pass(pass[3]), .err_count(err[3]),
    .first_err_idx(fidx[3]), .first_err_data(fdat[3])
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int         done_cyc;
  int         busy_cyc;
  int         ndone;
  logic [8:0] seq [16];
  logic       rs_busy;
  logic       rs_pass;
  logic [8:0] rs_stim;

  // Start unit u, then watch 60 cycles; cycle k is the k-th
  // falling edge after the start edge.
  task automatic run(input int u, input logic [8:0] sd,
                     input int rst_at, input int start2_at);
    done_cyc = 0;
    busy_cyc = 0;
    ndone    = 0;
    for (int i = 0; i < 16; i++) seq[i] = 9'h0;
    @(negedge clk);
    seed[u]  = sd;
    start[u] = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 60; k++) begin
      if (busy[u]) busy_cyc++;
      if (done[u]) begin
        ndone++;
        if (done_cyc == 0) done_cyc = k;
      end
      if ((k % 2) == 1 && (k - 1) / 2 < 16) seq[(k-1)/2] = stim[u];
      if (rst_at != 0 && k == rst_at + 1) begin
        rs_busy = busy[u];
        rs_pass = pass[u];
        rs_stim = stim[u];
      end
      start[u] = (k == start2_at);
      reset    = (k == rst_at);
      @(negedge clk);
    end
    start[u] = 1'b0;
    reset    = 1'b0;
  endtask

  logic [8:0] exp_b [8];
  logic [8:0] exp_d [3];

  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      seed[i]  = 9'h0;
    end
    exp_b = '{9'h1FC, 9'h1FD, 9'h1FE, 9'h1FF,
              9'h000, 9'h001, 9'h002, 9'h003};
`ifdef INV_CHECK_LFSR_EN
    exp_d = '{9'h001, 9'h110, 9'h088};
`else
    exp_d = '{9'h000, 9'h001, 9'h002};
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stim", 32'(stim[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_done", 32'(done[0]), 32'h0);
    chk("rst_pass", 32'(pass[0]), 32'h0);
    chk("rst_err",  32'(err[0]),  32'h0);
    chk("rst_fidx", 32'(fidx[0]), 32'h0);
    chk("rst_fdat", 32'(fdat[0]), 32'h0);
    reset = 1'b0;

`ifndef INV_CHECK_LFSR_EN
    run(0, 9'h00F, 0, 0);
    chk("t1_done_cyc", done_cyc, 33);
    chk("t1_busy_cyc", busy_cyc, 32);
    chk("t1_ndone",    ndone,    1);
    chk("t1_pass",     32'(pass[0]), 32'h1);
    chk("t1_err",      32'(err[0]),  32'h0);
    chk("t1_stim",     32'(stim[0]), 32'h01E);
    chk("t1_seq1",     32'(seq[1]),  32'h010);

    fmask = 9'h1FE;
    run(0, 9'h00F, 0, 0);
    chk("t2_err",   32'(err[0]),  32'h8);
    chk("t2_pass",  32'(pass[0]), 32'h0);
    chk("t2_fidx",  32'(fidx[0]), 32'h1);
    chk("t2_fdat",  32'(fdat[0]), 32'h1EE);
    chk("t2_done",  done_cyc, 33);
    fmask = 9'h1FF;

    run(1, 9'h1FC, 0, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_seq%0d", i), 32'(seq[i]), 32'(exp_b[i]));
    chk("t3_pass", 32'(pass[1]), 32'h1);
    chk("t3_done", done_cyc, 17);

    run(2, 9'h000, 0, 0);
    chk("t4_err",  32'(err[2]),  32'h7);
    chk("t4_pass", 32'(pass[2]), 32'h0);
    chk("t4_fidx", 32'(fidx[2]), 32'h0);
    chk("t4_fdat", 32'(fdat[2]), 32'h0);

    run(0, 9'h00F, 10, 0);
    chk("t5_rst_busy", 32'(rs_busy), 32'h0);
    chk("t5_rst_stim", 32'(rs_stim), 32'h0);
    chk("t5_rst_pass", 32'(rs_pass), 32'h0);
    chk("t5_ndone",    ndone, 0);

    run(0, 9'h00F, 0, 5);
    chk("t5_done_cyc", done_cyc, 33);
    chk("t5_ndone2",   ndone, 1);
    chk("t5_pass",     32'(pass[0]), 32'h1);
    chk("t5_stim",     32'(stim[0]), 32'h01E);
`endif

    run(3, 9'h000, 0, 0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t6_seq%0d", i), 32'(seq[i]), 32'(exp_d[i]));
    chk("t6_pass", 32'(pass[3]), 32'h1);
    chk("t6_done", done_cyc, 7);
    chk("t6_busy", busy_cyc, 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
